// File: rtl/pulse_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_timer_pkg
// Purpose  : Shared types and helpers for the multi-channel pulse timer.
//            Provides the channel state enum, the mode encodings, and the
//            channel-index width function.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_timer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // A single-channel build still needs a 1-bit index port.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_timer_ch.sv
`default_nettype none
// ============================================================================
// Module   : pulse_timer_ch
// Purpose  : One timer channel: load/mode registers, down-counter and the
//            IDLE/RUN state machine. Emits a registered one-cycle done pulse.
// Ports    : clk, rst_n (async, active-low)
//            i_tick          shared prescaler tick
//            i_ready         holdoff elapsed; gates start
//            i_cfg_we        config write already decoded for this channel
//            i_cfg_load      load value
//            i_cfg_periodic  mode bit (0 one-shot, 1 periodic)
//            i_start/i_stop  start/restart and stop strobes
//            o_done          expiry pulse
//            o_busy          channel is in RUN
// Revision : 1.0 - initial release
// ============================================================================
module pulse_timer_ch
    import pulse_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_ready,
    input  logic             i_cfg_we,
    input  logic [WIDTH-1:0] i_cfg_load,
    input  logic             i_cfg_periodic,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_done,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_load;
    logic             r_mode;
    logic             r_done;
    logic             w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (i_stop) begin
            // stop overrides start and a coincident expiry
            w_state_nxt = ST_IDLE;
            w_count_nxt = C_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && i_ready && (r_load != C_ZERO)) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = r_load;
                    end
                end
                ST_RUN: begin
                    if (i_start && i_ready) begin
                        // Restart takes priority over a coincident expiry;
                        // a zero load cannot run, so it drops to IDLE.
                        if (r_load != C_ZERO) begin
                            w_count_nxt = r_load;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = C_ZERO;
                        end
                    end else if (i_tick) begin
                        if (r_count == C_ONE) begin
                            w_done_nxt = 1'b1;
                            if ((r_mode == MODE_PERIODIC) && (r_load != C_ZERO)) begin
                                w_count_nxt = r_load;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_count_nxt = C_ZERO;
                            end
                        end else begin
                            w_count_nxt = r_count - C_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = C_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= C_ZERO;
            r_done  <= 1'b0;
            r_load  <= C_ZERO;
            r_mode  <= MODE_ONESHOT;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            // A write while running only affects the next start or reload.
            if (i_cfg_we) begin
                r_load <= i_cfg_load;
                r_mode <= i_cfg_periodic;
            end
        end
    end

    assign o_done = r_done;
    assign o_busy = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/pulse_timer_mc.sv
`default_nettype none
// ============================================================================
// Module   : pulse_timer_mc
// Purpose  : Multi-channel programmable down-counting timer. Holds the shared
//            prescaler, the post-reset holdoff counter and the config decode;
//            each channel is a pulse_timer_ch instance.
// Ports    : clk, rst_n (async, active-low)
//            cfg_we/cfg_ch/cfg_load/cfg_periodic  channel config write
//            start/stop   per-channel strobes
//            done         per-channel one-cycle expiry pulse
//            busy         per-channel RUN indicator
//            ready        holdoff elapsed
// Option   : PULSE_TIMER_IRQ_STICKY_EN adds irq_status/irq_clr/irq sticky
//            interrupt bits (set on done, cleared by irq_clr, set wins).
// Revision : 1.0 - initial release
// ============================================================================
module pulse_timer_mc
    import pulse_timer_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int WIDTH    = 16,
    parameter  int PRESCALE = 1,
    parameter  int HOLDOFF  = 16,
    localparam int CH_W     = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_load,
    input  logic              cfg_periodic,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] busy,
    output logic              ready
`ifdef PULSE_TIMER_IRQ_STICKY_EN
    ,
    output logic [NUM_CH-1:0] irq_status,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic              irq
`endif
);

    logic w_tick;
    logic w_ready;

    // Prescaler: free-running, not re-phased by start.
    generate
        if (PRESCALE <= 1) begin : g_no_prescale
            assign w_tick = 1'b1;
        end else begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0] C_PRE_ONE  = PW'(1);
            logic [PW-1:0] r_pre;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pre <= '0;
                end else if (r_pre == C_PRE_LAST) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + C_PRE_ONE;
                end
            end
            assign w_tick = (r_pre == C_PRE_LAST);
        end
    endgenerate

    // Holdoff: ready rises on the HOLDOFF-th edge after reset release.
    generate
        if (HOLDOFF == 0) begin : g_no_holdoff
            assign w_ready = 1'b1;
        end else begin : g_holdoff
            localparam int HW = $clog2(HOLDOFF + 1);
            localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLDOFF - 1);
            localparam logic [HW-1:0] C_HOLD_ONE  = HW'(1);
            logic [HW-1:0] r_hold;
            logic          r_ready;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold  <= '0;
                    r_ready <= 1'b0;
                end else if (!r_ready) begin
                    r_hold <= r_hold + C_HOLD_ONE;
                    if (r_hold == C_HOLD_LAST) begin
                        r_ready <= 1'b1;
                    end
                end
            end
            assign w_ready = r_ready;
        end
    endgenerate

    assign ready = w_ready;

    // Only indices below NUM_CH get a decoder, so out-of-range writes vanish.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic w_cfg_we;
            assign w_cfg_we = cfg_we & (cfg_ch == CH_W'(gi));
            pulse_timer_ch #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk            (clk),
                .rst_n          (rst_n),
                .i_tick         (w_tick),
                .i_ready        (w_ready),
                .i_cfg_we       (w_cfg_we),
                .i_cfg_load     (cfg_load),
                .i_cfg_periodic (cfg_periodic),
                .i_start        (start[gi]),
                .i_stop         (stop[gi]),
                .o_done         (done[gi]),
                .o_busy         (busy[gi])
            );
        end
    endgenerate

`ifdef PULSE_TIMER_IRQ_STICKY_EN
    logic [NUM_CH-1:0] r_irq_status;
    logic [NUM_CH-1:0] w_irq_status_nxt;
    logic              r_irq;

    // Set has priority over clear in the same cycle.
    assign w_irq_status_nxt = (r_irq_status & ~irq_clr) | done;

    // irq is registered from the next status so it tracks irq_status exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_status <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_irq_status <= w_irq_status_nxt;
            r_irq        <= |w_irq_status_nxt;
        end
    end

    assign irq_status = r_irq_status;
    assign irq        = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_timer_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_timer_mc
// Purpose  : Self-checking bench. Two timer instances (PRESCALE=1/HOLDOFF=16
//            and PRESCALE=4/HOLDOFF=0) share one stimulus stream. A reference
//            model computes each channel's expiry edge by arithmetic and
//            queues expected done events; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_timer_mc;

    localparam int NCH = 5;
    localparam int W   = 16;
    localparam int CHW = 3;
    localparam int NI  = 2;
    localparam int P0  = 1;
    localparam int P1  = 4;
    localparam int H0  = 16;
    localparam int H1  = 0;

    function automatic int pre_of(input int i);
        return (i == 0) ? P0 : P1;
    endfunction
    function automatic int hold_of(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [W-1:0]   cfg_load = '0;
    logic           cfg_periodic = 1'b0;
    logic [NCH-1:0] start = '0;
    logic [NCH-1:0] stop = '0;
    logic [NCH-1:0] done0, busy0, done1, busy1;
    logic           ready0, ready1;
`ifdef PULSE_TIMER_IRQ_STICKY_EN
    logic [NCH-1:0] irq_status0, irq_status1;
    logic [NCH-1:0] irq_clr = '0;
    logic           irq0, irq1;
`endif

    always #5 clk = ~clk;

    pulse_timer_mc #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(P0), .HOLDOFF(H0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_load(cfg_load), .cfg_periodic(cfg_periodic),
        .start(start), .stop(stop), .done(done0), .busy(busy0), .ready(ready0)
`ifdef PULSE_TIMER_IRQ_STICKY_EN
        , .irq_status(irq_status0), .irq_clr(irq_clr), .irq(irq0)
`endif
    );

    pulse_timer_mc #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(P1), .HOLDOFF(H1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_load(cfg_load), .cfg_periodic(cfg_periodic),
        .start(start), .stop(stop), .done(done1), .busy(busy1), .ready(ready1)
`ifdef PULSE_TIMER_IRQ_STICKY_EN
        , .irq_status(irq_status1), .irq_clr(irq_clr), .irq(irq1)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        int k;
        int inst;
        int ch;
    } exp_t;

    exp_t q[$];
    int   k_edge;          // edges since reset release
    bit   run_m [NI][NCH];
    int   dl    [NI][NCH]; // absolute edge of next expiry
    int   ld_m  [NCH];
    bit   per_m [NCH];

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            k_edge = 0;
            q.delete();
            for (int c = 0; c < NCH; c++) begin
                ld_m[c]  = 0;
                per_m[c] = 1'b0;
                for (int i = 0; i < NI; i++) begin
                    run_m[i][c] = 1'b0;
                    dl[i][c]    = 0;
                end
            end
        end else begin
            k_edge++;
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (stop[c]) begin
                        run_m[i][c] = 1'b0;
                    end else if (start[c] && (k_edge > hold_of(i))) begin
                        if (ld_m[c] != 0) begin
                            run_m[i][c] = 1'b1;
                            // ticks fall on edges that are multiples of P
                            dl[i][c] = ((k_edge / pre_of(i)) + 1) * pre_of(i)
                                       + (ld_m[c] - 1) * pre_of(i);
                        end else begin
                            run_m[i][c] = 1'b0;
                        end
                    end else if (run_m[i][c] && (k_edge == dl[i][c])) begin
                        e.k = k_edge; e.inst = i; e.ch = c;
                        q.push_back(e);
                        if (per_m[c] && (ld_m[c] != 0)) dl[i][c] += ld_m[c] * pre_of(i);
                        else run_m[i][c] = 1'b0;
                    end
                end
            end
            if (cfg_we && (int'(cfg_ch) < NCH)) begin
                ld_m[cfg_ch]  = int'(cfg_load);
                per_m[cfg_ch] = cfg_periodic;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int inst,
                       input logic [NCH-1:0] act, input logic [NCH-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s inst%0d edge %0d: got %b expected %b",
                      nm, inst, k_edge, act, expv);
    endtask

    initial begin
        logic [NCH-1:0] ev, eb, ad, ab;
        logic           ar;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            for (int i = 0; i < NI; i++) begin
                ev = '0;
                eb = '0;
                while ((q.size() > 0) && (q[0].inst == i) && (q[0].k <= k_edge)) begin
                    ev[q[0].ch] = 1'b1;
                    void'(q.pop_front());
                end
                for (int c = 0; c < NCH; c++) eb[c] = run_m[i][c];
                ad = (i == 0) ? done0 : done1;
                ab = (i == 0) ? busy0 : busy1;
                ar = (i == 0) ? ready0 : ready1;
                chk("done", i, ad, ev);
                chk("busy", i, ab, eb);
                chk("ready", i, {{(NCH-1){1'b0}}, ar},
                    {{(NCH-1){1'b0}}, (k_edge >= hold_of(i))});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we, input int ch, input int ld, input logic per,
                        input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
        @(negedge clk);
        cfg_we       = we;
        cfg_ch       = CHW'(ch);
        cfg_load     = W'(ld);
        cfg_periodic = per;
        start        = st;
        stop         = sp;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 0, 0, 1'b0, '0, '0);
    endtask

    task automatic rand_phase(input int n);
        int ld;
        logic [NCH-1:0] st, sp;
        for (int j = 0; j < n; j++) begin
            ld = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12));
            for (int c = 0; c < NCH; c++) begin
                st[c] = ($urandom_range(0, 11) == 0);
                sp[c] = ($urandom_range(0, 39) == 0);
            end
            step(($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)), ld,
                 1'($urandom_range(0, 1)), st, sp);
        end
    endtask

    initial begin
        #22 rst_n = 1'b1;                      // first edge after release: t=25
        // configuration, including one out-of-range channel write
        step(1'b1, 0, 3,  1'b0, '0, '0);
        step(1'b1, 1, 4,  1'b1, '0, '0);
        step(1'b1, 2, 10, 1'b0, '0, '0);
        step(1'b1, 3, 2,  1'b1, '0, '0);
        step(1'b1, 6, 99, 1'b1, '0, '0);
        // start during holdoff, then after it
        step(1'b0, 0, 0, 1'b0, 5'b00001, '0);  // edge 7
        idle(12);
        step(1'b0, 0, 0, 1'b0, 5'b00001, '0);  // edge 20
        idle(8);
        // periodic ch1, stop coinciding with the third expiry
        step(1'b0, 0, 0, 1'b0, 5'b00010, '0);
        idle(11);
        step(1'b0, 0, 0, 1'b0, '0, 5'b00010);
        idle(3);
        // one-shot ch2 restarted midway
        step(1'b0, 0, 0, 1'b0, 5'b00100, '0);
        idle(4);
        step(1'b0, 0, 0, 1'b0, 5'b00100, '0);
        idle(13);
        // zero load start is ignored
        step(1'b1, 0, 0, 1'b0, '0, '0);
        step(1'b0, 0, 0, 1'b0, 5'b00001, '0);
        idle(3);
        // reload picks up a load written while running
        step(1'b0, 0, 0, 1'b0, 5'b01000, '0);
        step(1'b1, 3, 7, 1'b1, '0, '0);
        idle(20);
        step(1'b0, 0, 0, 1'b0, '0, 5'b01000);
        idle(3);
        rand_phase(400);
        idle(3);
        // asynchronous reset in the middle of a count
        for (int c = 0; c < NCH; c++) step(1'b1, c, 6, 1'(c % 2), '0, '0);
        step(1'b0, 0, 0, 1'b0, 5'b11111, '0);
        idle(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        idle(25);
        rand_phase(150);
        idle(40);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_timer_mc.md
Name: pulse_timer_mc

Overview:
Multi-channel programmable down-counting timer, parametrised successor to the single-shot pulse timer in the add_hbird peripheral set.
- NUM_CH independent channels, each with its own load value and one-shot/periodic mode.
- All channels share one prescaler tick.
- Each channel emits a single-cycle done pulse on expiry.
- A synthesizable post-reset holdoff replaces simulation-only start delays; accelerator control logic uses the block for timeouts and periodic triggers.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- WIDTH, 16, counter/load width in bits.
- PRESCALE, 1, clk cycles per tick (>=1); 1 = tick every cycle.
- HOLDOFF, 16, clk cycles after reset release before ready asserts (0 = ready immediately).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_we  input  1  config write strobe.
- cfg_ch  input  CH_W=max(1,$clog2(NUM_CH))  channel index for config write.
- cfg_load  input  WIDTH  load value written to channel.
- cfg_periodic  input  1  mode written to channel: 0 one-shot, 1 periodic.
- start  input  NUM_CH  per-channel start/restart strobe.
- stop  input  NUM_CH  per-channel stop strobe.
- done  output  NUM_CH  per-channel expiry pulse, one clk wide.
- busy  output  NUM_CH  channel in RUN state.
- ready  output  1  holdoff elapsed; starts accepted.

Behaviour:
- Reset values: done=0, busy=0, ready=0 (1 if HOLDOFF=0). All load registers, counts and mode bits are 0. Holdoff counter and prescaler are 0.
- Holdoff: counter increments each clk from reset release. ready goes high at the edge where HOLDOFF cycles have elapsed, then stays high until reset. While ready=0, start is ignored; cfg writes and stop still take effect.
- Prescaler: free-running from reset, wraps at PRESCALE-1. tick=1 for one clk when it equals PRESCALE-1. With PRESCALE=1, tick is constantly 1. Tick is not re-phased by start, so first-interval jitter is 0..PRESCALE-1 cycles.
- Config write: on cfg_we, load[cfg_ch]<=cfg_load and mode[cfg_ch]<=cfg_periodic. cfg_ch>=NUM_CH is ignored. A write during RUN does not disturb the current count; the new load is used at the next reload or start.
- Per-channel FSM, states IDLE and RUN:
  - IDLE -> RUN on start & ready & load!=0; count<=load.
  - start with load==0 is ignored: stays IDLE, no done pulse.
  - RUN, on tick with count>1: count<=count-1.
  - RUN, on tick with count==1: done<=1 for next cycle. Periodic: count<=load, stay RUN (if load is now 0, go IDLE). One-shot: count<=0, go IDLE.
  - RUN, start without stop: restart, count<=load, no done pulse.
  - stop in any state: go IDLE, count<=0, no done pulse. stop wins over a simultaneous start and a simultaneous expiry.
- Latency: with PRESCALE=1, start sampled at edge E gives done high during the cycle after edge E+L (L=load). Periodic channels repeat every L*PRESCALE cycles.
- done is registered, never held more than one cycle per expiry; consecutive pulses are possible only if L*PRESCALE==1.
- busy is high exactly while the FSM is in RUN.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Async reset mid-count returns everything to reset values, including ready and holdoff.
- Count arithmetic is unsigned WIDTH bits; no wrap below 0 is reachable.

Optional Feature:
- Macro PULSE_TIMER_IRQ_STICKY_EN.
- Defined: adds ports irq_status output NUM_CH, irq_clr input NUM_CH, irq output 1.
  - irq_status[i] sets on done[i] and clears on irq_clr[i]; set wins if both occur in the same cycle.
  - irq = OR of irq_status; registered; reset 0.
- Undefined: ports absent, no sticky state; done is the only expiry indication.

Decomposition:
- Shared package pulse_timer_pkg: state enum {ST_IDLE, ST_RUN}, mode constants MODE_ONESHOT=0 / MODE_PERIODIC=1, CH_W function.
- Top holds the prescaler, holdoff counter and config decode.
- Sub-module pulse_timer_ch holds one channel's FSM, load/mode registers and count. It is instantiated NUM_CH times via generate.

Test Plan:
1. Reset, HOLDOFF=16; pulse start[0] at cycles 5 and 20 with load=3 -> first ignored (ready=0); second gives busy[0] for 3 cycles, then done[0] high 1 cycle, 3 cycles after the start edge.
2. PRESCALE=1, ch1 periodic load=4; start once -> done[1] pulses every 4 cycles; stop asserted same cycle as an expiry -> no pulse, busy[1]=0.
3. ch2 one-shot load=10; start, then restart at count=5 -> no done at original time; done 10 cycles after restart.
4. Start with load=0 -> busy stays 0, no done. Write load=7 while ch3 running with load=2 -> first expiry after 2, next period (periodic) after 7.
5. PRESCALE=4, load=2 -> done 5..8 cycles after start depending on prescaler phase. Assert rst_n low mid-count -> all outputs 0 asynchronously, ready re-holds.
6. With PULSE_TIMER_IRQ_STICKY_EN: done[0] and irq_clr[0] in same cycle -> irq_status[0]=1. irq_clr[0] later -> irq drops to 0 next cycle.
